// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-facing bundle between the ID-stage branch unit and the hazard controller:
// decode/forwarding inputs in one direction, front-end steering controls in the other.
interface branch_hazard_ctrl_if;
  logic [2:0] id_branch;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_reg_write;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       mem_mem_read;
  logic [4:0] mem_rd;
  logic       branch_taken;
  logic       pc_stall;
  logic       ifid_stall;
  logic       idex_bubble;
  logic       ifid_flush;
  logic       pc_redirect;

  modport master (
    output id_branch, id_rs, id_rt, ex_reg_write, ex_mem_read, ex_rd,
           mem_mem_read, mem_rd, branch_taken,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect
  );

  modport slave (
    input  id_branch, id_rs, id_rt, ex_reg_write, ex_mem_read, ex_rd,
           mem_mem_read, mem_rd, branch_taken,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: stalls until branch sources are available,
// redirects and flushes on taken branches, and keeps saturating branch statistics.
module branch_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned COUNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_hazard_ctrl_if.slave  bus,
  input  logic                 stats_clr,
  output logic                 busy,
  output logic [COUNT_W-1:0]   branch_count,
  output logic [COUNT_W-1:0]   taken_count,
  output logic [COUNT_W-1:0]   stall_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [2:0] FLUSH_LOAD  = 3'((FLUSH_CYCLES >= 2) ? (FLUSH_CYCLES - 2) : 0);

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] stall_cnt_q, stall_cnt_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  logic       valid_s;
  logic       uses_rt_s;
  logic       ex_hit_s;
  logic       mem_hit_s;
  logic [1:0] need_s;

  logic       stall_s;
  logic       flush_s;
  logic       redirect_s;
  logic       resolve_s;

  // Branch-code decode: which codes are real branches and which read rt.
  always_comb begin
    valid_s   = 1'b0;
    uses_rt_s = 1'b0;
    case (bus.id_branch)
      3'd1, 3'd2: begin
        valid_s   = 1'b1;
        uses_rt_s = 1'b1;
      end
      3'd3, 3'd4, 3'd5, 3'd6: begin
        valid_s   = 1'b1;
        uses_rt_s = 1'b0;
      end
      default: begin
        valid_s   = 1'b0;
        uses_rt_s = 1'b0;
      end
    endcase
  end

  // Source-register match against EX/MEM producers; $0 is hard-wired and never pending.
  always_comb begin
    ex_hit_s  = ((bus.id_rs != 5'd0) && (bus.id_rs == bus.ex_rd)) ||
                (uses_rt_s && (bus.id_rt != 5'd0) && (bus.id_rt == bus.ex_rd));
    mem_hit_s = ((bus.id_rs != 5'd0) && (bus.id_rs == bus.mem_rd)) ||
                (uses_rt_s && (bus.id_rt != 5'd0) && (bus.id_rt == bus.mem_rd));
    if (ex_hit_s && bus.ex_mem_read) begin
      need_s = 2'd2;
    end else if ((ex_hit_s && bus.ex_reg_write) || (mem_hit_s && bus.mem_mem_read)) begin
      need_s = 2'd1;
    end else begin
      need_s = 2'd0;
    end
  end

  // Next-state and output decode; branch_taken only matters in a hazard-free IDLE cycle.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_s     = 1'b0;
    flush_s     = 1'b0;
    redirect_s  = 1'b0;
    resolve_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_s && (need_s != 2'd0)) begin
          stall_s     = 1'b1;
          stall_cnt_d = need_s - 2'd1;
          if (need_s > 2'd1) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (valid_s) begin
          resolve_s = 1'b1;
          if (bus.branch_taken) begin
            redirect_s = 1'b1;
            flush_s    = 1'b1;
            if (MULTI_FLUSH) begin
              flush_cnt_d = FLUSH_LOAD;
              state_d     = ST_FLUSH;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        stall_s     = 1'b1;
        stall_cnt_d = stall_cnt_q - 2'd1;
        if (stall_cnt_q <= 2'd1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STALL;
        end
      end
      ST_FLUSH: begin
        flush_s = 1'b1;
        if (flush_cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
          state_d     = ST_FLUSH;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        stall_cnt_d = 2'd0;
        flush_cnt_d = 3'd0;
      end
    endcase
  end

  // FSM state and down-counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= 2'd0;
      flush_cnt_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Statistics counters; a clear wins over any event in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count <= {COUNT_W{1'b0}};
      taken_count  <= {COUNT_W{1'b0}};
      stall_count  <= {COUNT_W{1'b0}};
    end else if (stats_clr) begin
      branch_count <= {COUNT_W{1'b0}};
      taken_count  <= {COUNT_W{1'b0}};
      stall_count  <= {COUNT_W{1'b0}};
    end else begin
      if (resolve_s) begin
        branch_count <= sat_inc(branch_count);
      end
      if (resolve_s && bus.branch_taken) begin
        taken_count <= sat_inc(taken_count);
      end
      if (stall_s) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end

  assign bus.pc_stall    = stall_s;
  assign bus.ifid_stall  = stall_s;
  assign bus.idex_bubble = stall_s;
  assign bus.ifid_flush  = flush_s;
  assign bus.pc_redirect = redirect_s;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Sequences ID-stage branch resolution in the 5-stage MIPS32 pipeline.
- Decides when the branch comparison in ID may be trusted, and stalls the front end while a branch source register is still being produced in EX or MEM.
- When the branch resolver reports taken, redirects the PC and flushes the wrong-path fetch(es).
- Keeps saturating branch statistics counters for the debug/perf register block.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles ifid_flush is held after a taken branch; legal range 1..7.
COUNT_W, 32, width of each statistics counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
id_branch  input  3  branch code of the instruction in ID: 0 none, 1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, 7 reserved (treated as none).
id_rs  input  5  rs field of the ID instruction.
id_rt  input  5  rt field of the ID instruction.
ex_reg_write  input  1  EX-stage instruction writes a register.
ex_mem_read  input  1  EX-stage instruction is a load.
ex_rd  input  5  EX-stage destination register.
mem_mem_read  input  1  MEM-stage instruction is a load.
mem_rd  input  5  MEM-stage destination register.
branch_taken  input  1  combinational taken flag from the branch resolver for the ID instruction.
stats_clr  input  1  synchronous clear of all statistics counters.
pc_stall  output  1  hold the PC.
ifid_stall  output  1  hold the IF/ID register.
idex_bubble  output  1  insert a NOP into ID/EX.
ifid_flush  output  1  zero the IF/ID register.
pc_redirect  output  1  select the branch target as the next PC.
busy  output  1  FSM not in IDLE.
branch_count  output  COUNT_W  branches resolved.
taken_count  output  COUNT_W  branches resolved taken.
stall_count  output  COUNT_W  cycles in which pc_stall was high.

Behaviour:
- Reset (async, rst=1): state IDLE. All counters 0. All 1-bit outputs 0 as long as id_branch=0.
- Source registers: codes 1–2 use rs and rt. Codes 3–6 use rs only (compare against zero). Register 0 never creates a dependency.
- Hazard (IDLE, valid branch code) is the maximum of the following stall requirements:
  - EX load writing a source: need 2.
  - EX ALU result (ex_reg_write & ~ex_mem_read) writing a source: need 1.
  - MEM load writing a source: need 1.
- IDLE with hazard need N>0:
  - Same cycle: pc_stall=ifid_stall=idex_bubble=1.
  - Load stall_cnt=N-1; go to STALL if N-1>0, else stay in IDLE.
  - Re-evaluate every IDLE cycle.
- STALL:
  - All three stall outputs are 1.
  - stall_cnt decrements each cycle; at 0, return to IDLE.
  - Hazard inputs are ignored while in STALL.
- IDLE, valid branch, no hazard (resolve cycle):
  - branch_count+1.
  - If branch_taken: pc_redirect=1, ifid_flush=1, taken_count+1 in the same cycle. If FLUSH_CYCLES>1, load flush_cnt=FLUSH_CYCLES-2 and go to FLUSH.
  - If not taken: no control output asserted.
- FLUSH:
  - ifid_flush=1, pc_redirect=0, no stall outputs.
  - id_branch is ignored (ID holds a bubble).
  - flush_cnt decrements; at 0, return to IDLE.
- Resolution requires zero hazard. branch_taken is never sampled in a stall cycle.
- Counters:
  - Saturate at all-ones.
  - stall_count increments every cycle pc_stall=1.
  - stats_clr has priority: it clears all counters, and a same-cycle event is not counted.
- Code 7 and code 0 behave identically: no outputs, no counting.
- rst mid-STALL or mid-FLUSH: immediate return to IDLE; counters cleared.
- All outputs are combinational from state plus inputs. Counters and state are registered. No path exists from branch_taken to state except through the resolve decision.

Test Plan:
- Reset with random inputs, then id_branch=0 for 3 cycles -> all outputs 0, counters 0, busy 0.
- beq $1,$2 with ex_reg_write=1, ex_rd=2, ex_mem_read=0 -> one cycle of pc_stall/ifid_stall/idex_bubble=1; next cycle (hazard cleared), branch_taken=1 -> pc_redirect=1, ifid_flush=1; branch_count=1, taken_count=1, stall_count=1.
- bgez $3 with ex_mem_read=1, ex_rd=3; rt=3 on a bgtz instead -> first case: 2 stall cycles, busy=1 in the 2nd; bgtz with ex_rd=rt only: no stall.
- FLUSH_CYCLES=3, bne taken -> ifid_flush high exactly 3 cycles, pc_redirect high only the first; a branch code presented during cycles 2–3 is not counted.
- Source register $0 with ex_rd=0, ex_reg_write=1 -> no stall; not-taken -> branch_count+1, taken_count unchanged.
- COUNT_W=4, preload by 16 taken branches -> taken_count stays 15. stats_clr together with a taken branch -> all counters 0 next cycle. rst asserted in the 1st of 2 stall cycles -> IDLE, outputs follow IDLE rules.
